vend_sequencer: RTL and testbench

VEND_SEQUENCER -- requirements
Module: vend_sequencer

---
 rtl/vend_pkg.sv | 27 ++
 rtl/vend_timer.sv | 24 ++
 rtl/vend_sequencer.sv | 138 +++++++++++++
 tb/tb_vend_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/vend_pkg.sv
// Shared types for the vending sequencer: FSM states, coin codes and coin values.
package vend_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_VEND    = 2'd2,
    ST_CHANGE  = 2'd3
  } state_t;

  localparam logic [1:0] COIN_NONE = 2'b00;
  localparam logic [1:0] COIN_1    = 2'b01;
  localparam logic [1:0] COIN_2    = 2'b10;
  localparam logic [1:0] COIN_5    = 2'b11;

  localparam int CREDIT_W = 6;

  function automatic logic [2:0] coin_value(input logic [1:0] code);
    case (code)
      COIN_1:  return 3'd1;
      COIN_2:  return 3'd2;
      COIN_5:  return 3'd5;
      default: return 3'd0;
    endcase
  endfunction

endpackage

// File: rtl/vend_timer.sv
// Down-counter guarding the dispense handshake; expire fires on the last allowed cycle.
module vend_timer #(
  parameter int LOAD_VAL = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  input  logic count,
  output logic expire
);

  localparam int W = $clog2(LOAD_VAL + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (!reset)                  cnt <= '0;
    else if (load)               cnt <= W'(LOAD_VAL);
    else if (count && cnt != '0) cnt <= cnt - W'(1);
  end

  assign expire = count && (cnt == W'(1));

endmodule

// File: rtl/vend_sequencer.sv
// Vending machine sequencer: coin collection, product vend handshake and unit-by-unit change.
module vend_sequencer
  import vend_pkg::*;
#(
  parameter int PRICE0      = 3,
  parameter int PRICE1      = 4,
  parameter int PRICE2      = 5,
  parameter int PRICE3      = 7,
  parameter int CREDIT_MAX  = 20,
  parameter int ACK_TIMEOUT = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [1:0]          coin,
  input  logic                sel_valid,
  input  logic [1:0]          sel,
  input  logic                cancel,
  input  logic                dispense_ack,
  output logic                dispense_req,
  output logic [1:0]          dispense_id,
  output logic                change_pulse,
  output logic                coin_reject,
  output logic                price_short,
  output logic                fault,
  output logic                busy,
  output logic [CREDIT_W-1:0] credit
);

  function automatic logic [CREDIT_W-1:0] price_of(input logic [1:0] idx);
    case (idx)
      2'd0:    return CREDIT_W'(PRICE0);
      2'd1:    return CREDIT_W'(PRICE1);
      2'd2:    return CREDIT_W'(PRICE2);
      default: return CREDIT_W'(PRICE3);
    endcase
  endfunction

  state_t              state;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] sel_price;
  logic [CREDIT_W-1:0] remain;
  logic                coin_in;
  logic                idle_like;
  logic                vend_go;
  logic                in_vend;
  logic                expire;

  assign coin_in   = (coin != COIN_NONE);
  assign sum       = {1'b0, credit} + {{(CREDIT_W-2){1'b0}}, coin_value(coin)};
  assign sel_price = price_of(sel);
  assign remain    = credit - price_of(dispense_id);
  assign idle_like = (state == ST_IDLE) || (state == ST_COLLECT);
  assign vend_go   = reset && idle_like && sel_valid && (credit >= sel_price);
  assign in_vend   = (state == ST_VEND);

  vend_timer #(.LOAD_VAL(ACK_TIMEOUT)) u_timer (
    .clk    (clk),
    .reset  (reset),
    .load   (vend_go),
    .count  (in_vend),
    .expire (expire)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= ST_IDLE;
      credit       <= '0;
      dispense_req <= 1'b0;
      dispense_id  <= 2'd0;
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      price_short  <= 1'b0;
      fault        <= 1'b0;
      busy         <= 1'b0;
    end else begin
      change_pulse <= 1'b0;
      coin_reject  <= 1'b0;
      price_short  <= 1'b0;
      fault        <= 1'b0;
      unique case (state)
        ST_IDLE, ST_COLLECT: begin
          // select beats cancel beats coin; a coin that loses arbitration is bounced
          if (sel_valid) begin
            coin_reject <= coin_in;
            if (vend_go) begin
              state        <= ST_VEND;
              dispense_req <= 1'b1;
              dispense_id  <= sel;
              busy         <= 1'b1;
            end else begin
              price_short <= 1'b1;
            end
          end else if (cancel && state == ST_COLLECT) begin
            coin_reject <= coin_in;
            state       <= ST_CHANGE;
            busy        <= 1'b1;
          end else if (coin_in) begin
            if (sum <= (CREDIT_W+1)'(CREDIT_MAX)) begin
              credit <= sum[CREDIT_W-1:0];
              state  <= ST_COLLECT;
            end else begin
              coin_reject <= 1'b1;
            end
          end
        end
        ST_VEND: begin
          coin_reject <= coin_in;
          if (dispense_ack) begin
            dispense_req <= 1'b0;
            credit       <= remain;
            if (remain != '0) begin
              state <= ST_CHANGE;
            end else begin
              state <= ST_IDLE;
              busy  <= 1'b0;
            end
          end else if (expire) begin
            dispense_req <= 1'b0;
            fault        <= 1'b1;
            state        <= ST_CHANGE;
          end
        end
        ST_CHANGE: begin
          coin_reject <= coin_in;
          if (credit != '0) begin
            change_pulse <= 1'b1;
            credit       <= credit - CREDIT_W'(1);
          end
          if (credit <= CREDIT_W'(1)) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_vend_sequencer.sv
// Directed bench for vend_sequencer with a cycle-level reference model and per-cycle compare.
module tb_vend_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [1:0] coin = 2'b00;
  logic       sel_valid = 1'b0;
  logic [1:0] sel = 2'b00;
  logic       cancel = 1'b0;
  logic       dispense_ack = 1'b0;
  logic       dispense_req;
  logic [1:0] dispense_id;
  logic       change_pulse;
  logic       coin_reject;
  logic       price_short;
  logic       fault;
  logic       busy;
  logic [5:0] credit;

  always #5 clk = ~clk;

  vend_sequencer dut (
    .clk          (clk),
    .reset        (reset),
    .coin         (coin),
    .sel_valid    (sel_valid),
    .sel          (sel),
    .cancel       (cancel),
    .dispense_ack (dispense_ack),
    .dispense_req (dispense_req),
    .dispense_id  (dispense_id),
    .change_pulse (change_pulse),
    .coin_reject  (coin_reject),
    .price_short  (price_short),
    .fault        (fault),
    .busy         (busy),
    .credit       (credit)
  );

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference model: mode 0 = waiting for coins, 1 = dispensing, 2 = paying change
  int price[4]      = '{3, 4, 5, 7};
  int coin_units[4] = '{0, 1, 2, 5};
  int m_mode = 0, m_credit = 0, m_id = 0, m_wait = 0;
  int m_pulse = 0, m_rej = 0, m_short = 0, m_fault = 0;
  bit chk_en = 1'b0;

  always @(posedge clk) begin
    m_pulse = 0; m_rej = 0; m_short = 0; m_fault = 0;
    if (!reset) begin
      m_mode = 0; m_credit = 0; m_id = 0; m_wait = 0;
    end else begin
      case (m_mode)
        0: begin
          if (sel_valid) begin
            m_rej = (coin != 2'b00) ? 1 : 0;
            if (m_credit >= price[sel]) begin
              m_mode = 1; m_id = int'(sel); m_wait = 0;
            end else m_short = 1;
          end else if (cancel && m_credit > 0) begin
            m_rej = (coin != 2'b00) ? 1 : 0;
            m_mode = 2;
          end else if (coin != 2'b00) begin
            if (m_credit + coin_units[coin] <= 20) m_credit += coin_units[coin];
            else m_rej = 1;
          end
        end
        1: begin
          m_rej = (coin != 2'b00) ? 1 : 0;
          if (dispense_ack) begin
            m_credit -= price[m_id];
            m_mode = (m_credit > 0) ? 2 : 0;
          end else begin
            m_wait++;
            if (m_wait == 16) begin m_fault = 1; m_mode = 2; end
          end
        end
        default: begin
          m_rej = (coin != 2'b00) ? 1 : 0;
          m_pulse = 1;
          m_credit--;
          if (m_credit == 0) m_mode = 0;
        end
      endcase
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("credit",       32'(credit),       32'(m_credit));
      check("dispense_req", 32'(dispense_req), (m_mode == 1) ? 32'd1 : 32'd0);
      if (m_mode == 1) check("dispense_id", 32'(dispense_id), 32'(m_id));
      check("change_pulse", 32'(change_pulse), 32'(m_pulse));
      check("coin_reject",  32'(coin_reject),  32'(m_rej));
      check("price_short",  32'(price_short),  32'(m_short));
      check("fault",        32'(fault),        32'(m_fault));
      check("busy",         32'(busy),         (m_mode != 0) ? 32'd1 : 32'd0);
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic put_coin(input logic [1:0] c);
    coin = c;
    step();
    coin = 2'b00;
  endtask

  initial begin
    int pulses;
    int k;
    reset = 1'b0;
    step(2);
    chk_en = 1'b1;
    check("rst_credit", 32'(credit), 32'd0);
    check("rst_req",    32'(dispense_req), 32'd0);
    check("rst_busy",   32'(busy), 32'd0);
    check("rst_pulse",  32'(change_pulse), 32'd0);
    reset = 1'b1;

    // two 2-unit coins then product 0 (price 3) -> 1 unit change
    put_coin(2'b10);
    put_coin(2'b10);
    check("s1_credit", 32'(credit), 32'd4);
    sel = 2'd0; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("s1_req", 32'(dispense_req), 32'd1);
    check("s1_id",  32'(dispense_id), 32'd0);
    step(3);
    check("s1_req_held", 32'(dispense_req), 32'd1);
    dispense_ack = 1'b1;
    step();
    dispense_ack = 1'b0;
    check("s1_req_drop", 32'(dispense_req), 32'd0);
    check("s1_remain",   32'(credit), 32'd1);
    pulses = 0;
    for (int i = 0; i < 6; i++) begin step(); pulses += int'(change_pulse); end
    check("s1_pulses", 32'(pulses), 32'd1);
    check("s1_idle",   32'(busy), 32'd0);

    // short on price: credit 2, product 3
    put_coin(2'b10);
    sel = 2'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("s2_short",  32'(price_short), 32'd1);
    check("s2_credit", 32'(credit), 32'd2);
    step();
    check("s2_short_once", 32'(price_short), 32'd0);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step(4);

    // credit ceiling: 18 + 5 rejected, 18 + 2 accepted
    for (int i = 0; i < 3; i++) put_coin(2'b11);
    for (int i = 0; i < 3; i++) put_coin(2'b01);
    check("s3_credit18", 32'(credit), 32'd18);
    put_coin(2'b11);
    check("s3_reject",  32'(coin_reject), 32'd1);
    check("s3_kept18",  32'(credit), 32'd18);
    put_coin(2'b10);
    check("s3_credit20", 32'(credit), 32'd20);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step(24);

    // ack timeout: credit 7, product 3, no ack
    put_coin(2'b11);
    put_coin(2'b10);
    check("s4_credit7", 32'(credit), 32'd7);
    sel = 2'd3; sel_valid = 1'b1;
    step();
    sel_valid = 1'b0;
    check("s4_req", 32'(dispense_req), 32'd1);
    check("s4_id",  32'(dispense_id), 32'd3);
    k = 0;
    for (int i = 1; i <= 30; i++) begin
      step();
      if (fault) begin k = i; break; end
    end
    check("s4_fault_cycle", 32'(k), 32'd16);
    check("s4_refund_credit", 32'(credit), 32'd7);
    pulses = 0;
    for (int i = 0; i < 10; i++) begin step(); pulses += int'(change_pulse); end
    check("s4_pulses", 32'(pulses), 32'd7);

    // select + cancel + coin together at credit 5 on product 2
    put_coin(2'b11);
    sel = 2'd2; sel_valid = 1'b1; cancel = 1'b1; coin = 2'b01;
    step();
    sel_valid = 1'b0; cancel = 1'b0; coin = 2'b00;
    check("s5_req",    32'(dispense_req), 32'd1);
    check("s5_id",     32'(dispense_id), 32'd2);
    check("s5_reject", 32'(coin_reject), 32'd1);
    put_coin(2'b10);
    check("s5_vend_reject", 32'(coin_reject), 32'd1);
    dispense_ack = 1'b1;
    step();
    dispense_ack = 1'b0;
    check("s5_credit0", 32'(credit), 32'd0);
    check("s5_idle",    32'(busy), 32'd0);
    dispense_ack = 1'b1;
    step();
    dispense_ack = 1'b0;
    check("s5_stray_ack", 32'(busy), 32'd0);

    // reset during change at credit 3
    put_coin(2'b11);
    cancel = 1'b1;
    step();
    cancel = 1'b0;
    step(2);
    check("s6_credit3", 32'(credit), 32'd3);
    reset = 1'b0;
    step();
    reset = 1'b1;
    check("s6_credit0", 32'(credit), 32'd0);
    check("s6_busy",    32'(busy), 32'd0);
    pulses = 0;
    for (int i = 0; i < 4; i++) begin step(); pulses += int'(change_pulse); end
    check("s6_no_pulses", 32'(pulses), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
